// File: rtl/sub4_serial.sv
// Bit-serial subtractor: {borrow_out, result} = a - b - borrow_in, one bit per clock, LSB first.
// Optional macro SUB4_SERIAL_CLAMP_EN saturates result to zero when the final borrow is set.
module sub4_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               br_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               borrow_out_q;

  logic               diff_bit;
  logic               br_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   result_d;

  // Single full-subtractor cell on the current LSBs; difference bit enters the accumulator MSB.
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    acc_d    = (acc_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
`ifdef SUB4_SERIAL_CLAMP_EN
    result_d = br_d ? '0 : acc_d;
`else
    result_d = acc_d;
`endif
  end

  // Control FSM and datapath; the last shift edge loads the outputs so done is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      br_q         <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= borrow_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            result_q     <= result_d;
            borrow_out_q <= br_d;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= borrow_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_sub4_serial.sv
// Directed self-checking bench for sub4_serial (default WIDTH=4); honours SUB4_SERIAL_CLAMP_EN.
module tb_sub4_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       borrow_out;

  int n_tests = 0;
  int n_fail  = 0;

  sub4_serial #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {borrow_out, result} for one operation, including the clamp build.
  function automatic logic [4:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mbi);
    logic [4:0] r;
    r = 5'({1'b0, ma} - {1'b0, mb} - {4'b0, mbi});
`ifdef SUB4_SERIAL_CLAMP_EN
    if (r[4]) r = 5'h10;
`endif
    return r;
  endfunction

  // Accept one operation from IDLE and return cycles from accepting edge to done (99 on timeout).
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbi, output int lat);
    a = ta; b = tb; borrow_in = tbi; start = 1'b1;
    tick();
    start = 1'b0;
    a = 4'hx; b = 4'hx; borrow_in = 1'bx;
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat;
  int ndone;
  logic [4:0] seen;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_borrow", 32'(borrow_out), 0);
    rst = 1'b0;
    tick();

    // Basic subtract 9 - 3; also confirm busy in first shift cycle via separate look.
    a = 4'd9; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("basic_busy", 32'(busy), 1);
    lat = 99;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    check("basic_lat", 32'(lat), 5);
    check("basic_res", 32'({borrow_out, result}), 32'h06);
    check("basic_busy_done", 32'(busy), 0);
    tick();
    check("basic_pulse", 32'(done), 0);
    check("basic_hold", 32'(result), 6);

    run_op(4'd3, 4'd9, 1'b0, lat);
    check("uflow1_lat", 32'(lat), 5);
`ifdef SUB4_SERIAL_CLAMP_EN
    check("uflow1_res", 32'({borrow_out, result}), 32'h10);
`else
    check("uflow1_res", 32'({borrow_out, result}), 32'h1A);
`endif
    tick();

    run_op(4'd0, 4'd0, 1'b1, lat);
    check("uflow2_lat", 32'(lat), 5);
`ifdef SUB4_SERIAL_CLAMP_EN
    check("uflow2_res", 32'({borrow_out, result}), 32'h10);
`else
    check("uflow2_res", 32'({borrow_out, result}), 32'h1F);
`endif
    tick();

    // Exhaustive back-to-back: start held, next vector driven in each DONE cycle.
    a = 4'd0; b = 4'd0; borrow_in = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      logic [3:0] va, vb;
      logic       vbi;
      va = 4'(i); vb = 4'(i >> 4); vbi = 1'(i >> 8);
      ndone = 0;
      for (int k = 1; k <= 4; k++) begin
        if (done) ndone++;
        tick();
      end
      check("b2b_gap", 32'(ndone), 0);
      check("b2b_done", 32'(done), 1);
      check("b2b_res", 32'({borrow_out, result}), 32'(model(va, vb, vbi)));
      if (i == 511) start = 1'b0;
      else begin
        a = 4'(i + 1); b = 4'((i + 1) >> 4); borrow_in = 1'((i + 1) >> 8);
      end
      tick();
    end
    check("b2b_idle_busy", 32'(busy), 0);
    tick();

    // Start while busy: 7 - 2 in flight, 15 - 0 requested mid-shift.
    a = 4'd7; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 4'd15; b = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; seen = '0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin ndone++; seen = {borrow_out, result}; end
      tick();
    end
    check("sbusy_ndone", 32'(ndone), 1);
    check("sbusy_res", 32'(seen), 32'h05);
    check("sbusy_idle", 32'(busy), 0);

    // Reset two cycles into SHIFT.
    a = 4'd9; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_busy", 32'(busy), 0);
    check("rmid_done", 32'(done), 0);
    check("rmid_result", 32'(result), 0);
    check("rmid_borrow", 32'(borrow_out), 0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("rmid_quiet", 32'(ndone), 0);

    // Reset coincident with start wins.
    a = 4'd5; b = 4'd1; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rstart_busy", 32'(busy), 0);
    tick();
    check("rstart_busy2", 32'(busy), 0);

    run_op(4'd12, 4'd5, 1'b1, lat);
    check("post_lat", 32'(lat), 5);
    check("post_res", 32'({borrow_out, result}), 32'h06);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
